// File: rtl/pulse_emitter.sv
// pulse_emitter: source of detector-like raw pulses. Emits periodic multi-cycle-high
// pulses on two channels (B offset from A), either continuously while enable is high or
// for a single period per trigger. All outputs are registered.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   enable       continuous emission while high
//   trigger      one-period strobe, honoured only in IDLE
//   load         capture period/width/delay_b (immediate in IDLE, deferred to period end in RUN)
//   period       cycles per period (values below 2 behave as 2)
//   width        high cycles per pulse (clamped to period-1; 0 suppresses output)
//   delay_b      rise offset of channel B relative to channel A
//   count_clr    synchronous clear of pulse_count (wins over increment)
//   raw_a/raw_b  raw pulse outputs
//   busy         high while running
//   pulse_count  number of channel-A pulses emitted (wraps)
module pulse_emitter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        trigger,
  input  logic        load,
  input  logic [15:0] period,
  input  logic [7:0]  width,
  input  logic [7:0]  delay_b,
  input  logic        count_clr,
  output logic        raw_a,
  output logic        raw_b,
  output logic        busy,
  output logic [31:0] pulse_count
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q;
  logic [15:0] pcnt_q;
  logic        oneshot_q;
  // Active configuration
  logic [15:0] period_q;
  logic [7:0]  width_q;
  logic [7:0]  delay_q;
  // Pending configuration captured while running
  logic        pend_q;
  logic [15:0] pend_period_q;
  logic [7:0]  pend_width_q;
  logic [7:0]  pend_delay_q;

  function automatic logic [16:0] eff_period(input logic [15:0] p);
    return (p < 16'd2) ? 17'd2 : {1'b0, p};
  endfunction

  function automatic logic [16:0] eff_width(input logic [15:0] p, input logic [7:0] w);
    logic [16:0] pm1;
    pm1 = eff_period(p) - 17'd1;
    return ({9'd0, w} > pm1) ? pm1 : {9'd0, w};
  endfunction

  function automatic logic a_on(input logic [15:0] pc, input logic [16:0] w);
    return {1'b0, pc} < w;
  endfunction

  // pc < P always holds, so a B pulse running past the period end is cut off naturally.
  function automatic logic b_on(input logic [15:0] pc, input logic [7:0] d,
                                input logic [16:0] w);
    logic [16:0] pc17;
    logic [16:0] d17;
    pc17 = {1'b0, pc};
    d17  = {9'd0, d};
    return (pc17 >= d17) && (pc17 < d17 + w);
  endfunction

  logic [15:0] idle_period, wrap_period;
  logic [7:0]  idle_width, wrap_width, idle_delay, wrap_delay;
  logic [16:0] idle_w, wrap_w, act_w;
  logic [15:0] pcnt_inc;
  logic        at_end;
  logic [31:0] count_inc;

  always_comb begin
    // Config that takes effect when starting from IDLE
    idle_period = load ? period  : period_q;
    idle_width  = load ? width   : width_q;
    idle_delay  = load ? delay_b : delay_q;
    // Config that takes effect at a period boundary; a same-edge load is the latest value
    wrap_period = load ? period  : (pend_q ? pend_period_q : period_q);
    wrap_width  = load ? width   : (pend_q ? pend_width_q  : width_q);
    wrap_delay  = load ? delay_b : (pend_q ? pend_delay_q  : delay_q);
    idle_w      = eff_width(idle_period, idle_width);
    wrap_w      = eff_width(wrap_period, wrap_width);
    act_w       = eff_width(period_q, width_q);
    pcnt_inc    = pcnt_q + 16'd1;
    at_end      = {1'b0, pcnt_q} >= (eff_period(period_q) - 17'd1);
    count_inc   = pulse_count + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pcnt_q        <= '0;
      oneshot_q     <= 1'b0;
      period_q      <= 16'd100;
      width_q       <= 8'd4;
      delay_q       <= 8'd0;
      pend_q        <= 1'b0;
      pend_period_q <= '0;
      pend_width_q  <= '0;
      pend_delay_q  <= '0;
      raw_a         <= 1'b0;
      raw_b         <= 1'b0;
      busy          <= 1'b0;
      pulse_count   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          period_q <= idle_period;
          width_q  <= idle_width;
          delay_q  <= idle_delay;
          if (enable || trigger) begin
            state_q   <= StRun;
            pcnt_q    <= '0;
            oneshot_q <= trigger;
            busy      <= 1'b1;
            raw_a     <= a_on(16'd0, idle_w);
            raw_b     <= b_on(16'd0, idle_delay, idle_w);
            if (idle_w != 17'd0) pulse_count <= count_inc;
          end else begin
            raw_a <= 1'b0;
            raw_b <= 1'b0;
            busy  <= 1'b0;
          end
        end
        StRun: begin
          if (at_end) begin
            period_q <= wrap_period;
            width_q  <= wrap_width;
            delay_q  <= wrap_delay;
            pend_q   <= 1'b0;
            pcnt_q   <= '0;
            if (oneshot_q || !enable) begin
              state_q   <= StIdle;
              oneshot_q <= 1'b0;
              busy      <= 1'b0;
              raw_a     <= 1'b0;
              raw_b     <= 1'b0;
            end else begin
              raw_a <= a_on(16'd0, wrap_w);
              raw_b <= b_on(16'd0, wrap_delay, wrap_w);
              if (wrap_w != 17'd0) pulse_count <= count_inc;
            end
          end else begin
            pcnt_q <= pcnt_inc;
            raw_a  <= a_on(pcnt_inc, act_w);
            raw_b  <= b_on(pcnt_inc, delay_q, act_w);
            if (load) begin
              pend_q        <= 1'b1;
              pend_period_q <= period;
              pend_width_q  <= width;
              pend_delay_q  <= delay_b;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
      if (count_clr) pulse_count <= '0;
    end
  end

endmodule

// File: tb/tb_pulse_emitter.sv
// Testbench for pulse_emitter: a period-level reference model predicts the outputs after
// every clock edge and queues them; a monitor pops and compares each cycle. Directed
// scenarios add end-to-end checks on pulse counts, busy length and edge spacing.
module tb_pulse_emitter;

  logic        clk = 1'b0;
  logic        rst_n, enable, trigger, load, count_clr;
  logic [15:0] period;
  logic [7:0]  width, delay_b;
  logic        raw_a, raw_b, busy;
  logic [31:0] pulse_count;

  always #5 clk = ~clk;

  pulse_emitter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .trigger    (trigger),
    .load       (load),
    .period     (period),
    .width      (width),
    .delay_b    (delay_b),
    .count_clr  (count_clr),
    .raw_a      (raw_a),
    .raw_b      (raw_b),
    .busy       (busy),
    .pulse_count(pulse_count)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        a;
    logic        b;
    logic        bsy;
    logic [31:0] cnt;
  } exp_t;
  exp_t expq[$];

  // Reference model: a period is described by its start edge and its P, W, D values.
  longint    cyc = 0;
  bit        m_run = 0, m_one = 0, m_pv = 0;
  longint    m_start = 0;
  int        m_p = 2, m_w = 0, m_d = 0;
  int        a_per = 100, a_wid = 4, a_del = 0;
  int        p_per = 0, p_wid = 0, p_del = 0;
  bit [31:0] m_cnt = 0;

  function automatic void start_period();
    m_p     = (a_per < 2) ? 2 : a_per;
    m_w     = (a_wid > m_p - 1) ? m_p - 1 : a_wid;
    m_d     = a_del;
    m_start = cyc;
    if (m_w > 0) m_cnt = m_cnt + 1;
  endfunction

  always @(posedge clk) begin
    exp_t   e;
    longint off;
    cyc++;
    if (!rst_n) begin
      m_run = 0; m_one = 0; m_pv = 0; m_cnt = 0;
      a_per = 100; a_wid = 4; a_del = 0;
    end else begin
      if (!m_run) begin
        if (load) begin a_per = period; a_wid = width; a_del = delay_b; end
        if (enable || trigger) begin
          m_run = 1;
          m_one = trigger;
          start_period();
        end
      end else if (cyc - m_start == m_p) begin
        if (load) begin a_per = period; a_wid = width; a_del = delay_b; end
        else if (m_pv) begin a_per = p_per; a_wid = p_wid; a_del = p_del; end
        m_pv = 0;
        if (m_one || !enable) begin
          m_run = 0;
          m_one = 0;
        end else begin
          start_period();
        end
      end else if (load) begin
        p_per = period; p_wid = width; p_del = delay_b; m_pv = 1;
      end
      if (count_clr) m_cnt = 0;
    end
    if (m_run) begin
      off   = cyc - m_start;
      e.a   = off < m_w;
      e.b   = (off >= m_d) && (off < m_d + m_w);
      e.bsy = 1'b1;
    end else begin
      e.a = 1'b0; e.b = 1'b0; e.bsy = 1'b0;
    end
    e.cnt = m_cnt;
    expq.push_back(e);
  end

  // Monitor
  always @(posedge clk) begin
    exp_t e;
    #1;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL monitor: no expected entry at cycle %0d", cyc);
    end else begin
      e = expq.pop_front();
      if (raw_a !== e.a || raw_b !== e.b || busy !== e.bsy || pulse_count !== e.cnt) begin
        errors++;
        $display("FAIL cycle%0d: got a=%b b=%b busy=%b cnt=%0d, expected a=%b b=%b busy=%b cnt=%0d",
                 cyc, raw_a, raw_b, busy, pulse_count, e.a, e.b, e.bsy, e.cnt);
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_load(input int per, input int wid, input int del);
    load = 1'b1; period = 16'(per); width = 8'(wid); delay_b = 8'(del);
    tick();
    load = 1'b0;
  endtask

  task automatic clr();
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 1000; i++) begin
      if (!busy) break;
      tick();
    end
    chk("drain_busy", busy, 0);
  endtask

  task automatic trig_measure(output int nb, output int na, output int nbb);
    nb = 0; na = 0; nbb = 0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!busy) break;
      nb  += int'(busy);
      na  += int'(raw_a);
      nbb += int'(raw_b);
      tick();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, na, nbb, c0, pa, r0, r1, r2, nr;
    logic [3:0] seq;
    rst_n = 1'b0; enable = 1'b0; trigger = 1'b0; load = 1'b0; count_clr = 1'b0;
    period = '0; width = '0; delay_b = '0;
    repeat (3) tick();
    chk("reset_raw_a", raw_a, 0);
    chk("reset_busy", busy, 0);
    chk("reset_count", pulse_count, 0);
    rst_n = 1'b1;
    tick();

    // Reset configuration 100/4/0
    trig_measure(nb, na, nbb);
    chk("rstcfg_busy", nb, 100);
    chk("rstcfg_a", na, 4);
    chk("rstcfg_b", nbb, 4);

    // Continuous 17/5/0 for 100 cycles
    clr();
    do_load(17, 5, 0);
    enable = 1'b1;
    na = 0;
    for (int i = 0; i < 100; i++) begin tick(); na += int'(raw_a); end
    enable = 1'b0;
    for (int i = 0; i < 1000 && busy; i++) begin tick(); na += int'(raw_a); end
    chk("cont_count", pulse_count, 6);
    chk("cont_a_cycles", na, 30);

    // One trigger 20/4/18: B truncated at period end
    clr();
    do_load(20, 4, 18);
    trig_measure(nb, na, nbb);
    chk("trig_busy", nb, 20);
    chk("trig_a", na, 4);
    chk("trig_b", nbb, 2);
    chk("trig_count", pulse_count, 1);

    // Degenerate period/width
    do_load(1, 9, 0);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin seq[3-i] = raw_a; tick(); end
    enable = 1'b0;
    chk("p1_toggle", seq, 4'b1010);
    drain();
    do_load(20, 0, 0);
    c0 = int'(pulse_count);
    enable = 1'b1;
    na = 0;
    for (int i = 0; i < 50; i++) begin tick(); na += int'(raw_a) + int'(raw_b); end
    enable = 1'b0;
    drain();
    chk("w0_count_hold", pulse_count, c0);
    chk("w0_no_pulse", na, 0);

    // Load during RUN applies at the next period start
    do_load(30, 4, 0);
    enable = 1'b1;
    period = 16'd10; width = 8'd4; delay_b = 8'd0;
    tick();
    pa = 0; nr = 0; r0 = 0; r1 = 0; r2 = 0;
    for (int i = 0; i < 200 && nr < 3; i++) begin
      if (raw_a && !pa) begin
        if (nr == 0) r0 = i; else if (nr == 1) r1 = i; else r2 = i;
        nr++;
      end
      pa = int'(raw_a);
      load = (i == 5);
      tick();
      load = 1'b0;
    end
    enable = 1'b0;
    chk("defer_rises", nr, 3);
    chk("defer_first", r1 - r0, 30);
    chk("defer_second", r2 - r1, 10);
    drain();

    // Reset mid-pulse, then clear racing an increment
    clr();
    do_load(3, 2, 0);
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (pulse_count == 5 && raw_a) break;
    end
    chk("pre_rst_count", pulse_count, 5);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_a", raw_a, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_count", pulse_count, 0);
    rst_n = 1'b1;
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    enable = 1'b0;
    chk("clr_wins_count", pulse_count, 0);
    chk("clr_wins_a", raw_a, 1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      trigger   = ($urandom_range(0, 19) == 0);
      load      = ($urandom_range(0, 14) == 0);
      count_clr = ($urandom_range(0, 49) == 0);
      period    = 16'($urandom_range(0, 40));
      width     = 8'($urandom_range(0, 45));
      delay_b   = 8'($urandom_range(0, 45));
      tick();
    end
    rst_n = 1'b1; enable = 1'b0; trigger = 1'b0; load = 1'b0; count_clr = 1'b0;
    drain();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_emitter.md
PULSE_EMITTER -- requirements
Module: pulse_emitter

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: enable  input  1  continuous emission while high.
REQ-004 SHALL have port: trigger  input  1  single-cycle strobe; emits exactly one period from IDLE.
REQ-005 SHALL have port: load  input  1  strobe; captures period/width/delay_b into shadow config.
REQ-006 SHALL have port: period  input  16  cycles per emission period.
REQ-007 SHALL have port: width  input  8  high time of each raw pulse, in cycles.
REQ-008 SHALL have port: delay_b  input  8  rise offset of channel B after channel A, in cycles.
REQ-009 SHALL have port: count_clr  input  1  synchronous clear of pulse_count.
REQ-010 SHALL have port: raw_a  output  1  detector-like raw pulse, channel A.
REQ-011 SHALL have port: raw_b  output  1  detector-like raw pulse, channel B.
REQ-012 SHALL have port: busy  output  1  high while in RUN.
REQ-013 SHALL have port: pulse_count  output  32  number of channel-A pulses emitted.

Function
REQ-014 SHALL be the source end of the raw-signal path: it generates multi-cycle-high pulses that the downstream edge detector reduces to one-cycle pulses.
REQ-015 SHALL register all outputs; no combinational path from any input to any output.
REQ-016 SHALL implement states IDLE and RUN, plus a one-shot flag set by trigger.
REQ-017 IDLE->RUN when enable=1 or trigger=1 is sampled at edge k; raw_a SHALL be high from cycle k+1 (period counter pcnt=0).
REQ-018 In RUN, pcnt SHALL count 0..P-1 and wrap to 0, where P = max(period_l, 2) and period_l is the latched config value.
REQ-019 raw_a SHALL be high iff pcnt < W, where W = min(width_l, P-1); raw_a is therefore low for at least 1 cycle per period.
REQ-020 raw_b SHALL be high iff delay_l <= pcnt < delay_l+W, computed at 17 bits; a B pulse extending past P-1 SHALL be truncated at the period end and SHALL NOT carry into the next period.
REQ-021 width_l = 0 SHALL suppress raw_a and raw_b entirely; pulse_count SHALL NOT increment.
REQ-022 pulse_count SHALL increment by 1 at each cycle where pcnt=0 and W>0, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-023 count_clr SHALL force pulse_count to 0; count_clr wins over a simultaneous increment.
REQ-024 At pcnt=P-1: if one-shot flag set or enable=0, SHALL go to IDLE (flag cleared); otherwise SHALL continue with pcnt=0.
REQ-025 enable deasserted mid-period SHALL NOT truncate the current period; outputs complete normally, then IDLE.
REQ-026 trigger while in RUN SHALL be ignored.
REQ-027 load in IDLE SHALL update the active config immediately; load in RUN SHALL write a pending shadow applied at the next pcnt=0; a later load overwrites the pending value.
REQ-028 In IDLE, raw_a=raw_b=0, busy=0, pcnt=0.

Reset
REQ-029 rst_n=0 sampled on a rising edge SHALL force IDLE, raw_a=0, raw_b=0, busy=0, pulse_count=0, pcnt=0, one-shot flag=0, no pending config.
REQ-030 Reset config SHALL be period=100, width=4, delay_b=0.
REQ-031 Reset asserted mid-pulse SHALL drop raw_a/raw_b on the next edge; no partial-period completion.

Verification
REQ-032 load period=17,width=5,delay_b=0; enable=1 for 100 cycles -> raw_a and raw_b identical, high 5 of every 17 cycles; pulse_count=6 after deassert and drain.
REQ-033 period=20,width=4,delay_b=18; one trigger -> raw_a high pcnt 0-3; raw_b high pcnt 18-19 only; busy high exactly 20 cycles; pulse_count=1.
REQ-034 period=1,width=9 -> P=2, W=1: raw_a toggles 1,0,1,0; width=0 -> outputs stay 0 and pulse_count holds.
REQ-035 load period=10 during RUN with period=30 -> current period runs 30 cycles; next rising edge of raw_a after 10 further cycles.
REQ-036 rst_n=0 mid-pulse with pulse_count=5 -> next edge all outputs 0, pulse_count=0; count_clr with increment at same edge -> pulse_count=0.
